// File: rtl/fifo_4x8.sv
// fifo_4x8 : single-clock synchronous FIFO with a registered read port.
//
// Ports:
//   clk   - clock; every state update happens on its rising edge
//   clear - synchronous active-high reset; it overrides En/RW
//   En    - operation enable (1 = do the operation chosen by RW, 0 = idle)
//   RW    - operation select (1 = write/push, 0 = read/pop)
//   I     - write data, sampled only on an accepted write edge
//   O     - read data, registered; it changes only on an accepted read or on clear
//   Empty - high when the FIFO holds zero entries
//   Full  - high when the FIFO holds DEPTH entries
//
// The storage is a DEPTH x WIDTH memory. A write pointer, a read pointer
// and an occupancy count track the contents. DEPTH must be a power of two,
// so the pointers wrap from DEPTH-1 to 0 through natural overflow. A write
// to a full FIFO is ignored. A read from an empty FIFO is also ignored.
// clear does not reset the memory. Stale words cannot be read afterwards,
// because the count returns to zero and every later read must first be
// preceded by a write.
module fifo_4x8 #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             En,
  input  logic             RW,
  input  logic [WIDTH-1:0] I,
  output logic [WIDTH-1:0] O,
  output logic             Empty,
  output logic             Full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wptr_r;
  logic [AW-1:0]    rptr_r;
  logic [AW:0]      count_r;
  logic [WIDTH-1:0] o_r;

  logic             do_wr_s;
  logic             do_rd_s;
  logic             empty_s;
  logic             full_s;

  // Decode the flags from the registered count and qualify the requested operation.
  always_comb begin
    empty_s = (count_r == {(AW+1){1'b0}});
    full_s  = (count_r == FULL_COUNT);
    do_wr_s = En & RW & ~full_s;
    do_rd_s = En & ~RW & ~empty_s;
  end

  // Storage array: write the data on an accepted write; clear discards the write.
  always_ff @(posedge clk) begin
    if (do_wr_s && !clear) begin
      mem_r[wptr_r] <= I;
    end
  end

  // Pointers and occupancy count. RW picks one operation, so the count steps by at most one per cycle.
  always_ff @(posedge clk) begin
    if (clear) begin
      wptr_r  <= {AW{1'b0}};
      rptr_r  <= {AW{1'b0}};
      count_r <= {(AW+1){1'b0}};
    end else if (do_wr_s) begin
      wptr_r  <= wptr_r + AW'(1);
      count_r <= count_r + (AW+1)'(1);
    end else if (do_rd_s) begin
      rptr_r  <= rptr_r + AW'(1);
      count_r <= count_r - (AW+1)'(1);
    end
  end

  // Read data register: it updates only on an accepted read, and holds its value otherwise.
  always_ff @(posedge clk) begin
    if (clear) begin
      o_r <= {WIDTH{1'b0}};
    end else if (do_rd_s) begin
      o_r <= mem_r[rptr_r];
    end
  end

  assign O     = o_r;
  assign Empty = empty_s;
  assign Full  = full_s;

endmodule

// File: tb/tb_fifo_4x8.sv
// tb_fifo_4x8 : directed self-checking bench for fifo_4x8.
// A queue-based reference model follows the FIFO behaviour. A compare
// process checks O/Empty/Full against that model on every falling edge.
// Hand-computed literal checks pin the model at key points.
module tb_fifo_4x8;

  localparam int W = 4;
  localparam int D = 8;

  logic         clk;
  logic         clear;
  logic         En;
  logic         RW;
  logic [W-1:0] I;
  logic [W-1:0] O;
  logic         Empty;
  logic         Full;

  int errors;
  int checks;

  logic [W-1:0] model_q[$];
  logic [W-1:0] model_o;
  logic         cmp_on;

  fifo_4x8 #(.WIDTH(W), .DEPTH(D)) dut (
    .clk   (clk),
    .clear (clear),
    .En    (En),
    .RW    (RW),
    .I     (I),
    .O     (O),
    .Empty (Empty),
    .Full  (Full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Apply one cycle of stimulus, advance the model at the edge, then settle.
  task automatic step(input logic c, input logic en, input logic rw, input logic [W-1:0] d);
    clear = c;
    En    = en;
    RW    = rw;
    I     = d;
    @(posedge clk);
    if (c) begin
      model_q.delete();
      model_o = '0;
    end else if (en && rw) begin
      if (model_q.size() < D) model_q.push_back(d);
    end else if (en && !rw) begin
      if (model_q.size() > 0) model_o = model_q.pop_front();
    end
    #1;
  endtask

  // Compare the DUT outputs against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("model_O", int'(O), int'(model_o));
      chk("model_Empty", int'(Empty), (model_q.size() == 0) ? 1 : 0);
      chk("model_Full", int'(Full), (model_q.size() == D) ? 1 : 0);
    end
  end

  initial begin
    errors  = 0;
    checks  = 0;
    cmp_on  = 1'b0;
    model_o = '0;
    clear = 1'b0; En = 1'b0; RW = 1'b0; I = '0;

    // Clear, with a write requested in the same cycle; the write must be discarded.
    step(1'b1, 1'b1, 1'b1, 4'd7);
    cmp_on = 1'b1;
    chk("reset_O", int'(O), 0);
    chk("reset_Empty", int'(Empty), 1);
    chk("reset_Full", int'(Full), 0);

    // Write 1..4, then read them back.
    step(1'b0, 1'b1, 1'b1, 4'd1);
    chk("empty_after_first_write", int'(Empty), 0);
    chk("O_unchanged_by_write", int'(O), 0);
    for (int k = 2; k <= 4; k++) step(1'b0, 1'b1, 1'b1, W'(k));
    for (int k = 1; k <= 4; k++) begin
      step(1'b0, 1'b1, 1'b0, 4'hF);
      chk("order_1to4", int'(O), k);
    end
    chk("empty_after_4_reads", int'(Empty), 1);
    step(1'b0, 1'b0, 1'b0, 4'd9);
    chk("O_holds_4", int'(O), 4);

    // A read from an empty FIFO is ignored.
    step(1'b0, 1'b1, 1'b0, 4'd0);
    chk("empty_read_O", int'(O), 4);
    chk("empty_read_Empty", int'(Empty), 1);

    // Write 5..8 after the pointers have moved, then read them back.
    for (int k = 5; k <= 8; k++) step(1'b0, 1'b1, 1'b1, W'(k));
    for (int k = 5; k <= 8; k++) begin
      step(1'b0, 1'b1, 1'b0, 4'd0);
      chk("order_5to8", int'(O), k);
    end

    // Fill the FIFO across the wrap, try a write while full, then idle cycles.
    for (int k = 0; k < 8; k++) step(1'b0, 1'b1, 1'b1, W'(k));
    chk("full_after_8", int'(Full), 1);
    step(1'b0, 1'b1, 1'b1, 4'd9);
    chk("full_write_ignored_Full", int'(Full), 1);
    chk("full_write_O", int'(O), 8);
    step(1'b0, 1'b0, 1'b1, 4'd12);
    step(1'b0, 1'b0, 1'b0, 4'd13);
    chk("idle_Full", int'(Full), 1);
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b1, 1'b0, 4'd0);
      chk("order_0to7", int'(O), k);
    end
    chk("empty_after_drain", int'(Empty), 1);
    step(1'b0, 1'b1, 1'b0, 4'd0);
    chk("no_ninth_value", int'(O), 7);

    // Write three values, clear, then read; the stale contents must stay hidden.
    for (int k = 10; k <= 12; k++) step(1'b0, 1'b1, 1'b1, W'(k));
    step(1'b1, 1'b1, 1'b0, 4'd0);
    chk("clear_mid_Empty", int'(Empty), 1);
    chk("clear_mid_O", int'(O), 0);
    step(1'b0, 1'b1, 1'b0, 4'd0);
    chk("read_after_clear_O", int'(O), 0);
    chk("read_after_clear_Empty", int'(Empty), 1);

    // Fill completely, clear while full, then refill and confirm the pointers restart.
    for (int k = 0; k < 8; k++) step(1'b0, 1'b1, 1'b1, W'(15 - k));
    step(1'b1, 1'b0, 1'b0, 4'd0);
    chk("clear_full_Full", int'(Full), 0);
    step(1'b0, 1'b1, 1'b1, 4'd3);
    step(1'b0, 1'b1, 1'b0, 4'd0);
    chk("post_clear_data", int'(O), 3);

    step(1'b0, 1'b0, 1'b0, 4'd0);
    cmp_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_4x8.md
FIFO_4X8 -- requirements
Module: fifo_4x8

Interface
REQ-001 SHALL have parameter WIDTH, default 4: data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 8: number of storage entries; power of two, minimum 2.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port clear, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port En, input, 1: operation enable; 1 = perform the operation selected by RW this cycle, 0 = idle.
REQ-006 SHALL have port RW, input, 1: operation select; 1 = write (push), 0 = read (pop).
REQ-007 SHALL have port I, input, WIDTH: write data.
REQ-008 SHALL have port O, output, WIDTH: registered read data.
REQ-009 SHALL have port Empty, output, 1: high when the FIFO holds zero entries.
REQ-010 SHALL have port Full, output, 1: high when the FIFO holds DEPTH entries.

Function
REQ-011 SHALL store entries in a DEPTH x WIDTH memory with write pointer, read pointer and occupancy count.
REQ-012 Pointers SHALL be log2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-013 Occupancy count SHALL be log2(DEPTH)+1 bits, range 0..DEPTH.
REQ-014 Write SHALL occur on a rising edge with En=1, RW=1, Full=0: mem[wptr] <= I, wptr increments, count increments.
REQ-015 Write with Full=1 SHALL be ignored: memory, pointers, count and O unchanged; no overwrite.
REQ-016 Read SHALL occur on a rising edge with En=1, RW=0, Empty=0: O <= mem[rptr], rptr increments, count decrements.
REQ-017 Read data SHALL appear on O one cycle after the read edge, i.e. registered with one-cycle latency.
REQ-018 Read with Empty=1 SHALL be ignored: O holds its previous value; pointers and count unchanged.
REQ-019 With En=0, no state SHALL change; O, Empty and Full hold.
REQ-020 O SHALL change only on a successful read or clear; writes SHALL NOT affect O.
REQ-021 Empty SHALL equal (count == 0) and Full SHALL equal (count == DEPTH), both decoded combinationally from registered count, reflecting the state after the latest edge.
REQ-022 Data SHALL be returned in strict first-in first-out order across pointer wrap-around.
REQ-023 Because RW selects one operation, simultaneous read and write in one cycle SHALL NOT occur.
REQ-024 I SHALL be sampled only on the write edge; changes at other times SHALL have no effect.

Reset
REQ-025 clear=1 at a rising edge SHALL set wptr=0, rptr=0, count=0 and O=0, giving Empty=1 and Full=0 after that edge.
REQ-026 clear SHALL take priority over En/RW; any write or read in that cycle is discarded.
REQ-027 Memory contents need not be cleared; after clear, stale contents SHALL never be readable.
REQ-028 clear asserted mid-operation (partially filled or mid-wrap) SHALL yield the same state as REQ-025 on the next edge.

Verification
REQ-029 clear=1 for one edge, then En=1, RW=1 -> after the clear edge O=0, Empty=1, Full=0.
REQ-030 Write 1,2,3,4 on four consecutive edges (En=1, RW=1), then RW=0 for four edges -> Empty=0 after the first write; O shows 1,2,3,4 on successive cycles; Empty=1 after the fourth read; O holds 4 thereafter.
REQ-031 Write 5,6,7,8 then read four -> O=5,6,7,8, confirming order after pointers have advanced past 4.
REQ-032 Write 8 values 0..7 -> Full=1 after the eighth edge; ninth write of 9 is ignored; 8 reads return 0..7; Empty=1 afterwards.
REQ-033 Read from empty FIFO with O=4 -> O stays 4, Empty stays 1, count stays 0.
REQ-034 Write 3 values, assert clear, then read -> Empty=1 after clear; read ignored; O=0.
